// File: rtl/alu_op_sequencer_if.sv
// Request / ALU-control / result bundle for alu_op_sequencer.
// Handshakes: a transfer happens on a rising clk edge where valid && ready is high; the
// source keeps its payload stable from raising valid until that edge.
interface alu_op_sequencer_if #(
    parameter int BITS = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        opcode;
    logic [BITS-1:0]   X;
    logic [BITS-1:0]   Y;
    logic [11:0]       alu_ctrl;
    logic [BITS-1:0]   alu_x;
    logic [BITS-1:0]   alu_y;
    logic [2*BITS-1:0] alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [BITS-1:0]   result_hi;
    logic [BITS-1:0]   result_lo;
    logic              div_by_zero;
    logic              illegal_op;
    logic [2:0]        state_dbg;

    modport slave (
        input  op_valid, opcode, X, Y, alu_result, res_ready,
        output op_ready, alu_ctrl, alu_x, alu_y, res_valid,
               result_hi, result_lo, div_by_zero, illegal_op, state_dbg
    );

    modport master (
        output op_valid, opcode, X, Y, alu_result, res_ready,
        input  op_ready, alu_ctrl, alu_x, alu_y, res_valid,
               result_hi, result_lo, div_by_zero, illegal_op, state_dbg
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/sequencing controller for a one-hot ALU with internal shift-add multiply and
// restoring divide. Optional macro ALU_SEQ_EARLY_TERM_EN: multiply stops once the multiplier is exhausted.
module alu_op_sequencer #(
    parameter int BITS = 32
) (
    input logic               clk,
    input logic               clr,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(BITS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        MUL  = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              op_ready_q, op_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [11:0]       alu_ctrl_q, alu_ctrl_d;
    logic [BITS-1:0]   alu_x_q, alu_x_d;
    logic [BITS-1:0]   alu_y_q, alu_y_d;
    logic [BITS-1:0]   result_hi_q, result_hi_d;
    logic [BITS-1:0]   result_lo_q, result_lo_d;
    logic              div_by_zero_q, div_by_zero_d;
    logic              illegal_op_q, illegal_op_d;
    logic [2*BITS-1:0] a_q, a_d;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0]   b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [2*BITS-1:0] mul_sum;
    logic              mul_last;
    logic              iter_last;
    logic [BITS:0]     div_r2;
    logic [BITS:0]     div_diff;
    logic [BITS-1:0]   div_rem;
    logic [BITS-1:0]   div_quo;

    // Iteration datapath. MUL: a_q is the multiplicand pre-shifted by the iteration index.
    // DIV: acc_q holds {partial remainder, dividend/quotient shift register}.
    always_comb begin
        iter_last = (cnt_q == CW'(BITS - 1));
        mul_sum   = acc_q + (b_q[0] ? a_q : '0);
`ifdef ALU_SEQ_EARLY_TERM_EN
        mul_last  = iter_last || ((b_q >> 1) == '0);
`else
        mul_last  = iter_last;
`endif
        div_r2    = {acc_q[2*BITS-1:BITS], acc_q[BITS-1]};
        div_diff  = div_r2 - {1'b0, b_q};
        div_rem   = div_diff[BITS] ? div_r2[BITS-1:0] : div_diff[BITS-1:0];
        div_quo   = {acc_q[BITS-2:0], ~div_diff[BITS]};
    end

    always_comb begin
        state_d       = state_q;
        op_ready_d    = op_ready_q;
        res_valid_d   = res_valid_q;
        alu_ctrl_d    = '0;
        alu_x_d       = alu_x_q;
        alu_y_d       = alu_y_q;
        result_hi_d   = result_hi_q;
        result_lo_d   = result_lo_q;
        div_by_zero_d = div_by_zero_q;
        illegal_op_d  = illegal_op_q;
        a_d           = a_q;
        acc_d         = acc_q;
        b_d           = b_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    op_ready_d = 1'b0;
                    a_d        = {{BITS{1'b0}}, bus.X};
                    acc_d      = {{BITS{1'b0}}, bus.X};
                    b_d        = bus.Y;
                    cnt_d      = '0;
                    case (bus.opcode)
                        4'd2: begin
                            state_d = MUL;
                            acc_d   = '0;
                        end
                        4'd3: state_d = DIV;
                        4'd12, 4'd13, 4'd14, 4'd15: begin
                            state_d      = DONE;
                            res_valid_d  = 1'b1;
                            illegal_op_d = 1'b1;
                            result_hi_d  = '0;
                            result_lo_d  = '0;
                        end
                        default: begin
                            state_d    = EXEC;
                            alu_ctrl_d = 12'd1 << bus.opcode;
                            alu_x_d    = bus.X;
                            alu_y_d    = bus.Y;
                        end
                    endcase
                end
            end
            EXEC: begin
                {result_hi_d, result_lo_d} = bus.alu_result;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    {result_hi_d, result_lo_d} = mul_sum;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DIV: begin
                if (b_q == '0) begin
                    result_hi_d   = acc_q[BITS-1:0];
                    result_lo_d   = {BITS{1'b1}};
                    div_by_zero_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    acc_d = {div_rem, div_quo};
                    cnt_d = cnt_q + CW'(1);
                    if (iter_last) begin
                        result_hi_d = div_rem;
                        result_lo_d = div_quo;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d   = 1'b0;
                    div_by_zero_d = 1'b0;
                    illegal_op_d  = 1'b0;
                    op_ready_d    = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                op_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= IDLE;
            op_ready_q    <= 1'b1;
            res_valid_q   <= 1'b0;
            alu_ctrl_q    <= '0;
            alu_x_q       <= '0;
            alu_y_q       <= '0;
            result_hi_q   <= '0;
            result_lo_q   <= '0;
            div_by_zero_q <= 1'b0;
            illegal_op_q  <= 1'b0;
            a_q           <= '0;
            acc_q         <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            op_ready_q    <= op_ready_d;
            res_valid_q   <= res_valid_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_x_q       <= alu_x_d;
            alu_y_q       <= alu_y_d;
            result_hi_q   <= result_hi_d;
            result_lo_q   <= result_lo_d;
            div_by_zero_q <= div_by_zero_d;
            illegal_op_q  <= illegal_op_d;
            a_q           <= a_d;
            acc_q         <= acc_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.op_ready    = op_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.alu_x       = alu_x_q;
    assign bus.alu_y       = alu_y_q;
    assign bus.result_hi   = result_hi_q;
    assign bus.result_lo   = result_lo_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer (BITS=32) with an arithmetic reference
// model for results and latency, plus a behavioural one-hot ALU on alu_result.
module tb_alu_op_sequencer;
    localparam int BITS = 32;

    logic        clk;
    logic        clr;
    int          n_checks;
    int          n_fails;
    int          cyc;
    logic [63:0] exp_q[$];
    logic [1:0]  flg_q[$];
    logic [63:0] alu_result_drv;

    alu_op_sequencer_if #(.BITS(BITS)) bus ();

    alu_op_sequencer #(.BITS(BITS)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] t;
        logic [31:0] n;
        int          s;
        xx = {x, x};
        s  = int'(y[4:0]);
        n  = '0;
        case (op)
            4'd0:  return {32'h0, x} + {32'h0, y};
            4'd1:  return {32'h0, x} - {32'h0, y};
            4'd4:  n = x >> s;
            4'd5:  n = x << s;
            4'd6:  begin t = xx >> s; n = t[31:0];  end
            4'd7:  begin t = xx << s; n = t[63:32]; end
            4'd8:  n = x & y;
            4'd9:  n = x | y;
            4'd10: n = -x;
            4'd11: n = ~x;
            default: n = '0;
        endcase
        return {32'h0, n};
    endfunction

    // External ALU: decode the one-hot control and compute the selected function.
    always_comb begin
        alu_result_drv = 64'h0;
        for (int i = 0; i < 12; i++)
            if (bus.alu_ctrl == (12'd1 << i)) alu_result_drv = alu_ref(4'(i), bus.alu_x, bus.alu_y);
    end
    assign bus.alu_result = alu_result_drv;

    function automatic int mul_latency(input logic [31:0] y);
`ifdef ALU_SEQ_EARLY_TERM_EN
        int h;
        h = -1;
        for (int i = 0; i < 32; i++) if (y[i]) h = i;
        return ((h + 1 < 1) ? 1 : h + 1) + 1;
`else
        return BITS + 1;
`endif
    endfunction

    function automatic bit is_exec(input logic [3:0] op);
        return !(op == 4'd2 || op == 4'd3 || op >= 4'd12);
    endfunction

    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] r, output logic [1:0] f, output int lat);
        f = 2'b00;
        if (op == 4'd2) begin
            r   = {32'h0, x} * {32'h0, y};
            lat = mul_latency(y);
        end else if (op == 4'd3) begin
            if (y == 0) begin
                r   = {x, 32'hFFFF_FFFF};
                f   = 2'b10;
                lat = 2;
            end else begin
                r   = {x % y, x / y};
                lat = BITS + 1;
            end
        end else if (op >= 4'd12) begin
            r   = 64'h0;
            f   = 2'b01;
            lat = 1;
        end else begin
            r   = alu_ref(op, x, y);
            lat = 2;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_op_ready"}, 64'(bus.op_ready), 64'd1);
        check_eq({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check_eq({tag, "_alu_ctrl"}, 64'(bus.alu_ctrl), 64'd0);
        check_eq({tag, "_alu_xy"}, {bus.alu_x, bus.alu_y}, 64'd0);
        check_eq({tag, "_result"}, {bus.result_hi, bus.result_lo}, 64'd0);
        check_eq({tag, "_flags"}, 64'({bus.div_by_zero, bus.illegal_op}), 64'd0);
    endtask

    // Driver: issue one op at a negedge, follow it to the result handshake, end at a negedge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int hold, output int res_cyc);
        logic [63:0] exp_res;
        logic [1:0]  exp_flg;
        int          exp_lat;
        int          lat;
        int          ctrl_n;
        logic [11:0] ctrl_seen;
        logic        busy_bad;
        logic        hold_bad;
        logic [65:0] snap;
        model(op, x, y, exp_res, exp_flg, exp_lat);
        exp_q.push_back(exp_res);
        flg_q.push_back(exp_flg);

        check_eq("idle_op_ready", 64'(bus.op_ready), 64'd1);
        bus.op_valid  = 1'b1;
        bus.opcode    = op;
        bus.X         = x;
        bus.Y         = y;
        bus.res_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Keep valid asserted with garbage while busy: none of it may be accepted.
        bus.X      = $urandom;
        bus.Y      = $urandom;
        bus.opcode = 4'($urandom_range(0, 15));
        lat        = 1;
        ctrl_n     = 0;
        ctrl_seen  = '0;
        busy_bad   = 1'b0;
        while (!bus.res_valid && lat < 200) begin
            if (bus.alu_ctrl != '0) begin
                ctrl_n++;
                ctrl_seen = bus.alu_ctrl;
            end
            if (bus.op_ready) busy_bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res_cyc = cyc;
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("busy_op_ready", 64'(busy_bad), 64'd0);
        if (is_exec(op)) begin
            check_eq("alu_ctrl", 64'(ctrl_seen), 64'(12'd1 << op));
            check_eq("alu_ctrl_cycles", 64'(ctrl_n), 64'd1);
        end else begin
            check_eq("alu_ctrl_cycles", 64'(ctrl_n), 64'd0);
        end

        snap     = {bus.div_by_zero, bus.illegal_op, bus.result_hi, bus.result_lo};
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ({bus.div_by_zero, bus.illegal_op, bus.result_hi, bus.result_lo} != snap ||
                !bus.res_valid || bus.op_ready)
                hold_bad = 1'b1;
        end
        if (hold > 0) check_eq("hold_stable", 64'(hold_bad), 64'd0);
        bus.res_ready = 1'b1;

        // Scoreboard
        exp_res = exp_q.pop_front();
        exp_flg = flg_q.pop_front();
        check_eq("result", {bus.result_hi, bus.result_lo}, exp_res);
        check_eq("flags", 64'({bus.div_by_zero, bus.illegal_op}), 64'(exp_flg));
        check_eq("ctrl_in_done", 64'(bus.alu_ctrl), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        check_eq("res_valid_clear", 64'(bus.res_valid), 64'd0);
        check_eq("flags_clear", 64'({bus.div_by_zero, bus.illegal_op}), 64'd0);
        check_eq("ready_after", 64'(bus.op_ready), 64'd1);
        check_eq("result_kept", {bus.result_hi, bus.result_lo}, exp_res);
    endtask

    initial begin
        int          r0, r1, r2, rc;
        logic [3:0]  op;
        logic [31:0] x, y;
        logic        bad;
        bus.op_valid  = 1'b0;
        bus.opcode    = '0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.res_ready = 1'b0;
        clr           = 1'b0;
        #2 clr = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        clr = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(4'd0, 32'h5, 32'h3, 0, rc);
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, rc);
        do_op(4'd2, 32'hFFFF_FFFF, 32'h3, 1, rc);
        do_op(4'd2, 32'h1234_5678, 32'h0, 0, rc);
        do_op(4'd3, 32'd100, 32'd7, 2, rc);
        do_op(4'd3, 32'h1234, 32'h0, 0, rc);
        do_op(4'd3, 32'hFFFF_FFFF, 32'h1, 0, rc);
        do_op(4'd13, $urandom, $urandom, 5, rc);
        do_op(4'd6, 32'h8000_0001, 32'd4, 0, rc);
        do_op(4'd7, 32'h8000_0001, 32'd4, 0, rc);

        // Back-to-back add, sub, not
        do_op(4'd0, 32'd10, 32'd20, 0, r0);
        do_op(4'd1, 32'd3, 32'd5, 0, r1);
        do_op(4'd11, 32'h0F0F_0F0F, 32'h0, 0, r2);
        check_eq("b2b_gap1", 64'(r1 - r0), 64'd3);
        check_eq("b2b_gap2", 64'(r2 - r1), 64'd3);

        // Reset in the middle of a multiply
        bus.op_valid = 1'b1;
        bus.opcode   = 4'd2;
        bus.X        = $urandom;
        bus.Y        = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check_reset_vals("midop");
        @(negedge clk);
        clr = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.res_valid || !bus.op_ready) bad = 1'b1;
        end
        check_eq("no_stale_valid", 64'(bad), 64'd0);
        do_op(4'd0, 32'hFFFF_FFFF, 32'h2, 1, rc);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       y = 32'h0;
                1:       y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            do_op(op, x, y, $urandom_range(0, 2), rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        n_fails++;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
